// File: rtl/bnn_pe_sequencer.sv
// bnn_pe_sequencer: fetch/exec/capture sequencer for one binary PE over a conv layer.
// Optional threshold output under `ifdef PE_SEQ_BINARIZE_EN.
module bnn_pe_sequencer #(
  parameter int CH_W   = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic [CH_W-1:0]   num_ch_in,
  input  logic [ADDR_W-1:0] num_pix_in,
`ifdef PE_SEQ_BINARIZE_EN
  input  logic [6:0]        thresh_in,
  output logic              res_bit_out,
`endif
  output logic              busy_out,
  output logic              done_out,
  output logic              act_rd_out,
  output logic [ADDR_W-1:0] act_addr_out,
  input  logic [8:0]        act_data_in,
  output logic [CH_W-1:0]   wgt_addr_out,
  input  logic [8:0]        wgt_data_in,
  output logic [8:0]        pe_act_out,
  output logic [8:0]        pe_wgt_out,
  output logic [6:0]        pe_psum_out,
  input  logic [6:0]        pe_result_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
  output logic [6:0]        res_data_out
);
  typedef enum logic [2:0] {IDLE, FETCH, TAIL, SETTLE, OUT} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] n_q, n_d, ch_q, ch_d;
  logic [ADDR_W-1:0] p_q, p_d, pix_q, pix_d, addr_q, addr_d;
  logic ex_v_q, ex_v_d, ex_first_q, ex_first_d, res_valid_q, res_valid_d, done_q, done_d;
  logic [6:0] res_data_q, res_data_d;
  logic start, fetch, hs;
`ifdef PE_SEQ_BINARIZE_EN
  logic [6:0] thresh_q, thresh_d;
  logic res_bit_q, res_bit_d;
`endif
  assign start = state_q == IDLE && start_in;
  assign fetch = state_q == FETCH;
  assign hs    = state_q == OUT && res_ready_in;
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      n_q         <= '0;
      p_q         <= '0;
      ch_q        <= '0;
      pix_q       <= '0;
      addr_q      <= '0;
      ex_v_q      <= 1'b0;
      ex_first_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef PE_SEQ_BINARIZE_EN
      thresh_q    <= '0;
      res_bit_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      p_q         <= p_d;
      ch_q        <= ch_d;
      pix_q       <= pix_d;
      addr_q      <= addr_d;
      ex_v_q      <= ex_v_d;
      ex_first_q  <= ex_first_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
`ifdef PE_SEQ_BINARIZE_EN
      thresh_q    <= thresh_d;
      res_bit_q   <= res_bit_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_in ? FETCH : IDLE;
      FETCH:   state_d = ch_q == n_q ? TAIL : FETCH;
      TAIL:    state_d = SETTLE;
      SETTLE:  state_d = OUT;
      OUT:     state_d = !res_ready_in ? OUT : pix_q == p_q ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  // addr keeps running across pixels so pixel p, channel c lands at p*(N+1)+c
  always_comb begin
    n_d         = start ? num_ch_in : n_q;
    p_d         = start ? num_pix_in : p_q;
    ch_d        = start ? '0 : fetch ? (ch_q == n_q ? '0 : ch_q + 1'b1) : ch_q;
    addr_d      = start ? '0 : fetch ? addr_q + 1'b1 : addr_q;
    pix_d       = start ? '0 : (hs && pix_q != p_q) ? pix_q + 1'b1 : pix_q;
    ex_v_d      = fetch;
    ex_first_d  = fetch && ch_q == '0;
    res_valid_d = state_q == SETTLE ? 1'b1 : hs ? 1'b0 : res_valid_q;
    res_data_d  = state_q == SETTLE ? pe_result_in : res_data_q;
    done_d      = hs && pix_q == p_q;
`ifdef PE_SEQ_BINARIZE_EN
    thresh_d    = start ? thresh_in : thresh_q;
    res_bit_d   = state_q == SETTLE ? pe_result_in >= thresh_q : res_bit_q;
`endif
  end
  always_comb begin
    busy_out      = state_q != IDLE;
    done_out      = done_q;
    act_rd_out    = fetch;
    act_addr_out  = fetch ? addr_q : '0;
    wgt_addr_out  = fetch ? ch_q : '0;
    pe_act_out    = ex_v_q ? act_data_in : '0;
    pe_wgt_out    = ex_v_q ? wgt_data_in : '0;
    pe_psum_out   = (ex_v_q && !ex_first_q) ? pe_result_in : '0;
    res_valid_out = res_valid_q;
    res_data_out  = res_data_q;
`ifdef PE_SEQ_BINARIZE_EN
    res_bit_out   = res_bit_q;
`endif
  end
endmodule

// File: tb/tb_bnn_pe_sequencer.sv
// tb_bnn_pe_sequencer: random layers against a per-pixel XNOR-popcount reference model.
module tb_bnn_pe_sequencer;
  logic clk_in = 1'b0, rst_in = 1'b0, start_in = 1'b0, res_ready_in = 1'b1;
  logic [3:0] num_ch_in = '0, wgt_addr_out;
  logic [9:0] num_pix_in = '0, act_addr_out;
  logic [8:0] act_data_in = '0, wgt_data_in = '0, pe_act_out, pe_wgt_out;
  logic [6:0] pe_psum_out, pe_result_in = '0, res_data_out;
  logic busy_out, done_out, act_rd_out, res_valid_out;
  logic [6:0] thresh = 7'd10;
`ifdef PE_SEQ_BINARIZE_EN
  logic res_bit_out;
`endif
  logic [8:0] amem [1024];
  logic [8:0] wmem [16];
  int total = 0, bad = 0;

  bnn_pe_sequencer #(.CH_W(4), .ADDR_W(10)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .num_ch_in(num_ch_in), .num_pix_in(num_pix_in),
`ifdef PE_SEQ_BINARIZE_EN
    .thresh_in(thresh), .res_bit_out(res_bit_out),
`endif
    .busy_out(busy_out), .done_out(done_out),
    .act_rd_out(act_rd_out), .act_addr_out(act_addr_out), .act_data_in(act_data_in),
    .wgt_addr_out(wgt_addr_out), .wgt_data_in(wgt_data_in),
    .pe_act_out(pe_act_out), .pe_wgt_out(pe_wgt_out), .pe_psum_out(pe_psum_out),
    .pe_result_in(pe_result_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_data_out(res_data_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (act_rd_out) act_data_in <= amem[act_addr_out];
    wgt_data_in <= wmem[wgt_addr_out];
    pe_result_in <= 7'(pe_psum_out + 7'($countones(~(pe_act_out ^ pe_wgt_out))));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int partial(input int p, input int c, input int n);
    int s = 0;
    for (int j = 0; j < c; j++)
      s += $countones(~(amem[(p * (n + 1) + j) % 1024] ^ wmem[j]));
    return s % 128;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_rd"}, act_rd_out, 0);
    chk({tag, "_addr"}, {act_addr_out, wgt_addr_out}, 0);
    chk({tag, "_pe"}, {pe_act_out, pe_wgt_out, pe_psum_out}, 0);
    chk({tag, "_res"}, {res_valid_out, res_data_out}, 0);
`ifdef PE_SEQ_BINARIZE_EN
    chk({tag, "_bit"}, res_bit_out, 0);
`endif
  endtask

  task automatic run_layer(input int n, input int p, input bit bp, input bit nowait);
    int k = 0, fc = 0, cyc = 1, pc = 0, pp = 0, e;
    int budget = (p + 1) * (n + 40) + 50;
    bit pend = 0, seen_done = 0, hs_prev = 0;
    if (!nowait) @(negedge clk_in);
    start_in = 1; num_ch_in = 4'(n); num_pix_in = 10'(p);
    @(negedge clk_in);
    start_in = 0;
    while (!seen_done && cyc < budget) begin
      if (cyc == 1) chk("first_fetch", act_rd_out, 1);
      if (pend) begin
        chk("pe_act", pe_act_out, amem[(pp * (n + 1) + pc) % 1024]);
        chk("pe_wgt", pe_wgt_out, wmem[pc]);
        chk("pe_psum", pe_psum_out, partial(pp, pc, n));
      end else chk("pe_idle", {pe_act_out, pe_wgt_out, pe_psum_out}, 0);
      pend = act_rd_out;
      if (act_rd_out) begin
        chk("act_addr", act_addr_out, (k * (n + 1) + fc) % 1024);
        chk("wgt_addr", wgt_addr_out, fc);
        pc = fc; pp = k;
        fc = (fc == n) ? 0 : fc + 1;
      end
      if (hs_prev && !done_out) chk("fetch_after_hs", act_rd_out, 1);
      if (done_out) begin
        chk("done_count", k, p + 1);
        chk("busy_at_done", busy_out, 0);
        if (!bp) chk("layer_cycles", cyc - 1, (p + 1) * (n + 4));
        seen_done = 1;
      end else chk("busy", busy_out, 1);
      if (!seen_done) begin
        if (res_valid_out) begin
          e = partial(k, n + 1, n);
          chk("res_data", res_data_out, e);
          chk("rd_in_out", act_rd_out, 0);
`ifdef PE_SEQ_BINARIZE_EN
          chk("res_bit", res_bit_out, e >= int'(thresh));
`endif
        end
        res_ready_in = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
        hs_prev = res_valid_out && res_ready_in;
        if (hs_prev) k++;
        cyc++;
        @(negedge clk_in);
      end
    end
    if (!seen_done) chk("timeout", 0, 1);
    res_ready_in = 1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) amem[i] = 9'($urandom);
    for (int i = 0; i < 16; i++) wmem[i] = 9'($urandom);
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    rst_in = 1;
    amem[0] = 9'h1FF; wmem[0] = 9'h1FF;
    run_layer(0, 0, 0, 0);
    amem[0] = 9'h1FF; amem[1] = 9'h000; amem[2] = 9'h0F0;
    wmem[0] = 9'h1FF; wmem[1] = 9'h1FF; wmem[2] = 9'h0F0;
    run_layer(2, 0, 0, 1);
    run_layer(1, 2, 0, 0);
    run_layer(3, 2, 1, 0);
    @(negedge clk_in);
    start_in = 1; num_ch_in = 4'd3; num_pix_in = 10'd3;
    @(negedge clk_in);
    start_in = 0;
    repeat (8) @(negedge clk_in);
    chk("mid_fetch", {act_rd_out, act_addr_out}, {1'b1, 10'd5});
    rst_in = 0;
    @(negedge clk_in);
    check_zero("mid_reset");
    rst_in = 1;
    amem[0] = 9'h1FF; wmem[0] = 9'h1FF;
    run_layer(0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) amem[i] = 9'($urandom);
    for (int i = 0; i < 16; i++) wmem[i] = 9'($urandom);
    for (int t = 0; t < 8; t++) begin
      thresh = 7'($urandom);
      run_layer($urandom_range(0, 15), $urandom_range(0, 5), 1'($urandom), 1'($urandom));
    end
    thresh = 7'd64;
    run_layer(13, 80, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
